serial_host_tx: RTL and testbench

Host-side initiator for the TCK/TCS/TDI byte link. It drives the link toward the FPGA-side byte receiver.
- Software or the test harness loads up to DEPTH bytes into an internal buffer, then pulses start.
- The block generates TCK from the system clock, holds TCS low for the whole transaction, and shifts each byte out on TDI LSB first.
- The receiver reassembles the bytes in order at byte addresses 0..len-1.

---
 rtl/serial_link_pkg.sv | 28 ++
 rtl/serial_tx_buffer.sv | 36 +++
 rtl/serial_host_tx.sv | 201 ++++++++++++++++++++
 tb/tb_serial_host_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared constants for the TCK/TCS/TDI byte link.
// FSM encoding, link idle levels and bit-order helpers.
package serial_link_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOW  = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_TAIL = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic TCK_IDLE   = 1'b0;
    localparam logic TCS_ACTIVE = 1'b0;

    localparam int BITS_PER_BYTE = 8;
    localparam int LSB_FIRST     = 1;
    localparam int MAX_LEN       = 256;

    // Bit presented first on the wire for a freshly loaded byte.
    function automatic logic first_bit(input logic [7:0] d);
        return (LSB_FIRST != 0) ? d[0] : d[7];
    endfunction

    // Shift register advance so the next wire bit sits in first_bit position.
    function automatic logic [7:0] shift_out(input logic [7:0] d);
        return (LSB_FIRST != 0) ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/serial_tx_buffer.sv
// Byte buffer for the host transmitter.
// Simple dual-port RAM, write-first on an address collision, no reset.
module serial_tx_buffer #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; a same-cycle write to the read address is forwarded.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/serial_host_tx.sv
// Host-side initiator for the TCK/TCS/TDI byte link.
// Shifts buffered bytes out LSB first under a divided serial clock.
module serial_host_tx
    import serial_link_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8
) (
    input  logic              inCLK,
    input  logic              inRSTn,
    input  logic              inWrEn,
    input  logic [ADDR_W-1:0] inWrAddr,
    input  logic [7:0]        inWrData,
    input  logic              inStart,
    input  logic [8:0]        inLen,
    output logic              outBusy,
    output logic              outDone,
    output logic [8:0]        outBytesSent,
    output logic              outTCK,
    output logic              outTCS,
    output logic              outTDI
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [8:0] DEPTH_LEN = 9'(DEPTH);
    localparam logic [2:0] BIT_LAST  = 3'(BITS_PER_BYTE - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [8:0]        idx_q, idx_d;
    logic [8:0]        len_q, len_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        sh_q, sh_d;
    logic [8:0]        sent_q, sent_d;
    logic              tck_q, tck_d;
    logic              tcs_q, tcs_d;
    logic              tdi_q, tdi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0] rdata;
    logic [7:0] sh_shift;
    logic       div_end;
    logic       start_ok;
    logic       last_byte;

    serial_tx_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_i   (inCLK),
        .we_i    (inWrEn && !busy_q),
        .waddr_i (inWrAddr),
        .wdata_i (inWrData),
        .raddr_i (raddr_q),
        .rdata_o (rdata)
    );

    assign sh_shift  = shift_out(sh_q);
    assign div_end   = (div_q == DIV_LAST);
    assign last_byte = (idx_q == (len_q - 9'd1));
    assign start_ok  = inStart && (state_q == ST_IDLE) &&
                       (inLen != 9'd0) && (inLen <= DEPTH_LEN);

    // Next-state logic: phase timing, bit/byte sequencing and prefetch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        len_d   = len_q;
        raddr_d = raddr_q;
        sh_d    = sh_q;
        sent_d  = sent_q;
        tck_d   = tck_q;
        tcs_d   = tcs_q;
        tdi_d   = tdi_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_LOW;
                    div_d   = 8'd0;
                    bit_d   = 3'd0;
                    idx_d   = 9'd0;
                    len_d   = inLen;
                    sent_d  = 9'd0;
                    busy_d  = 1'b1;
                    tcs_d   = TCS_ACTIVE;
                    tck_d   = TCK_IDLE;
                    sh_d    = rdata;
                    tdi_d   = first_bit(rdata);
                    // Byte 1 is fetched long before byte 0 finishes.
                    if (inLen > 9'd1) begin
                        raddr_d = ADDR_W'(1);
                    end
                end
            end
            ST_LOW: begin
                if (div_end) begin
                    state_d = ST_HIGH;
                    div_d   = 8'd0;
                    tck_d   = ~TCK_IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (div_end) begin
                    div_d = 8'd0;
                    tck_d = TCK_IDLE;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
                        sent_d = sent_q + 9'd1;
                        if (last_byte) begin
                            state_d = ST_TAIL;
                            raddr_d = '0;
                        end else begin
                            state_d = ST_LOW;
                            idx_d   = idx_q + 9'd1;
                            sh_d    = rdata;
                            tdi_d   = first_bit(rdata);
                            if ((idx_q + 9'd2) < len_q) begin
                                raddr_d = raddr_q + ADDR_W'(1);
                            end
                        end
                    end else begin
                        state_d = ST_LOW;
                        sh_d    = sh_shift;
                        tdi_d   = first_bit(sh_shift);
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_TAIL: begin
                if (div_end) begin
                    state_d = ST_DONE;
                    div_d   = 8'd0;
                    tcs_d   = ~TCS_ACTIVE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tdi_d   = 1'b0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer silently.
    always_ff @(posedge inCLK or negedge inRSTn) begin
        if (!inRSTn) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            idx_q   <= 9'd0;
            len_q   <= 9'd0;
            raddr_q <= '0;
            sh_q    <= 8'd0;
            sent_q  <= 9'd0;
            tck_q   <= TCK_IDLE;
            tcs_q   <= ~TCS_ACTIVE;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            raddr_q <= raddr_d;
            sh_q    <= sh_d;
            sent_q  <= sent_d;
            tck_q   <= tck_d;
            tcs_q   <= tcs_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign outBusy      = busy_q;
    assign outDone      = done_q;
    assign outBytesSent = sent_q;
    assign outTCK       = tck_q;
    assign outTCS       = tcs_q;
    assign outTDI       = tdi_q;

endmodule

// File: tb/tb_serial_host_tx.sv
// Bench for serial_host_tx: two instances (CLK_DIV=2 and CLK_DIV=1)
// on shared stimulus, each compared every cycle with a timeline model.
module tb_serial_host_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [8:0] len;

    logic [1:0] w_tck, w_tcs, w_tdi, w_busy, w_done;
    logic [8:0] w_sent [2];

    always #5 clk = ~clk;

    serial_host_tx #(.CLK_DIV(2), .DEPTH(256), .ADDR_W(8)) dut2 (
        .inCLK(clk), .inRSTn(rst_n), .inWrEn(wr_en), .inWrAddr(wr_addr),
        .inWrData(wr_data), .inStart(start), .inLen(len),
        .outBusy(w_busy[0]), .outDone(w_done[0]), .outBytesSent(w_sent[0]),
        .outTCK(w_tck[0]), .outTCS(w_tcs[0]), .outTDI(w_tdi[0])
    );

    serial_host_tx #(.CLK_DIV(1), .DEPTH(256), .ADDR_W(8)) dut1 (
        .inCLK(clk), .inRSTn(rst_n), .inWrEn(wr_en), .inWrAddr(wr_addr),
        .inWrData(wr_data), .inStart(start), .inLen(len),
        .outBusy(w_busy[1]), .outDone(w_done[1]), .outBytesSent(w_sent[1]),
        .outTCK(w_tck[1]), .outTCS(w_tcs[1]), .outTDI(w_tdi[1])
    );

    int checks = 0;
    int errors = 0;
    int nprint = 0;
    int cyc = 0;

    // Model state: one transaction record per instance.
    bit         m_act  [2];
    int         m_t    [2];
    int         m_len  [2];
    int         m_prev [2];
    logic [7:0] mem    [2][256];
    logic [7:0] snap   [2][256];

    // Receiver-side observations.
    int rises    [2];
    int rx_nb    [2];
    int tcs_low  [2];
    int done_cnt [2];
    int done_cyc [2];
    bit rx_bits  [2][4096];
    logic prev_tck [2];

    function automatic int divof(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Last cycle of the transaction (DONE) for instance i.
    function automatic int mend(input int i);
        return m_t[i] + 16 * divof(i) * m_len[i] + divof(i) + 1;
    endfunction

    function automatic bit midle(input int i, input int c);
        return !m_act[i] || (c > mend(i));
    endfunction

    function automatic bit mbusy(input int i, input int c);
        return m_act[i] && (c > m_t[i]) && (c < mend(i));
    endfunction

    // Expected outputs during cycle c, from the transaction timeline.
    task automatic model_out(input int i, input int c,
                             output logic e_tck, output logic e_tcs,
                             output logic e_tdi, output logic e_busy,
                             output logic e_done, output bit care,
                             output int e_sent);
        int k, b, cd, nb;
        logic [7:0] v;
        cd = divof(i);
        e_tck = 1'b0; e_tcs = 1'b1; e_tdi = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; care = 1'b1;
        e_sent = m_prev[i];
        if (m_act[i] && c > m_t[i]) begin
            k = c - m_t[i] - 1;
            nb = 16 * cd * m_len[i];
            e_sent = m_len[i];
            if (k < nb) begin
                b = k / (2 * cd);
                v = snap[i][b / 8];
                e_tck = ((k % (2 * cd)) >= cd);
                e_tdi = v[b % 8];
                e_tcs = 1'b0;
                e_busy = 1'b1;
                e_sent = k / (16 * cd);
            end else if (k < nb + cd) begin
                e_tcs = 1'b0;
                e_busy = 1'b1;
                care = 1'b0;
            end else if (k == nb + cd) begin
                e_done = 1'b1;
            end
        end
    endtask

    // Model update at each edge: start acceptance and buffer writes.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i] = 1'b0;
                m_prev[i] = 0;
            end else begin
                bit wb;
                wb = mbusy(i, cyc);
                if (start && len >= 9'd1 && len <= 9'd256 && midle(i, cyc)) begin
                    if (m_act[i]) m_prev[i] = m_len[i];
                    m_act[i] = 1'b1;
                    m_t[i] = cyc;
                    m_len[i] = int'(len);
                    for (int a = 0; a < 256; a++) snap[i][a] = mem[i][a];
                end
                if (wr_en && !wb) mem[i][wr_addr] = wr_data;
            end
        end
        cyc++;
    end

    // Per-cycle compare plus receiver observation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic e_tck, e_tcs, e_tdi, e_busy, e_done;
            bit care;
            int e_sent;
            model_out(i, cyc, e_tck, e_tcs, e_tdi, e_busy, e_done, care, e_sent);
            if (!rst_n) begin
                e_tck = 1'b0; e_tcs = 1'b1; e_tdi = 1'b0;
                e_busy = 1'b0; e_done = 1'b0; care = 1'b1; e_sent = 0;
            end
            checks++;
            if (w_tck[i] !== e_tck || w_tcs[i] !== e_tcs ||
                w_busy[i] !== e_busy || w_done[i] !== e_done ||
                w_sent[i] !== 9'(e_sent) || (care && w_tdi[i] !== e_tdi)) begin
                errors++;
                if (nprint < 40) begin
                    nprint++;
                    $display("FAIL outputs inst%0d cyc=%0d got tck=%b tcs=%b tdi=%b busy=%b done=%b sent=%0d want tck=%b tcs=%b tdi=%b(care=%0d) busy=%b done=%b sent=%0d",
                             i, cyc, w_tck[i], w_tcs[i], w_tdi[i], w_busy[i],
                             w_done[i], w_sent[i], e_tck, e_tcs, e_tdi, care,
                             e_busy, e_done, e_sent);
                end
            end
            if (w_tck[i] === 1'b1 && prev_tck[i] !== 1'b1) begin
                rises[i]++;
                checks++;
                if (w_tcs[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL tck_rise_tcs_high inst%0d cyc=%0d got tcs=%b want 0",
                             i, cyc, w_tcs[i]);
                end
                if (rx_nb[i] < 4096) begin
                    rx_bits[i][rx_nb[i]] = w_tdi[i];
                    rx_nb[i]++;
                end
            end
            if (w_tcs[i] === 1'b0) tcs_low[i]++;
            if (w_done[i] === 1'b1) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
            prev_tck[i] = w_tck[i];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int rx_byte(input int i, input int j);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = rx_bits[i][j * 8 + b];
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            rises[i] = 0; rx_nb[i] = 0; tcs_low[i] = 0;
            done_cnt[i] = 0; done_cyc[i] = -1;
        end
    endtask

    task automatic do_write(input int a, input int d);
        wr_en = 1'b1; wr_addr = 8'(a); wr_data = 8'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int l, output int t);
        start = 1'b1; len = 9'(l); t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(midle(0, cyc) && midle(1, cyc)) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("wait_idle_timeout", 0, 1);
    endtask

    int t0;
    int seqA5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int exp4  [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
        start = 1'b0; len = 9'd0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_prev[i] = 0; m_t[i] = 0; m_len[i] = 0;
            prev_tck[i] = 1'b0;
            for (int a = 0; a < 256; a++) mem[i][a] = 8'h00;
        end
        clear_stats();
        repeat (3) tick();
        check("reset_tcs", int'(w_tcs), 3);
        check("reset_busy", int'(w_busy), 0);
        check("reset_sent", int'(w_sent[0]), 0);
        rst_n = 1'b1;
        tick();

        // Give every buffer entry a defined value.
        for (int a = 0; a < 256; a++) do_write(a, int'($urandom_range(0, 255)));

        // Single byte 0xA5.
        do_write(0, 8'hA5);
        clear_stats();
        do_start(1, t0);
        wait_idle(200);
        for (int b = 0; b < 8; b++) check("a5_tdi_bit", int'(rx_bits[0][b]), seqA5[b]);
        check("a5_tcs_low_div2", tcs_low[0], 34);
        check("a5_done_cyc_div2", done_cyc[0], t0 + 35);
        check("a5_done_cyc_div1", done_cyc[1], t0 + 18);
        check("a5_sent", int'(w_sent[0]), 1);
        check("a5_rises", rises[0], 8);

        // Four bytes; restart and write attempted while busy.
        for (int a = 0; a < 4; a++) do_write(a, exp4[a]);
        clear_stats();
        do_start(4, t0);
        repeat (5) tick();
        start = 1'b1; len = 9'd2;
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'h55;
        tick();
        start = 1'b0; wr_en = 1'b0;
        wait_idle(400);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) check("four_byte_rx", rx_byte(i, j), exp4[j]);
            check("four_byte_rises", rises[i], 32);
            check("four_byte_done", done_cnt[i], 1);
        end
        clear_stats();
        do_start(1, t0);
        wait_idle(200);
        check("busy_write_dropped", rx_byte(0, 0), 8'h01);

        // Illegal lengths.
        clear_stats();
        do_start(0, t0);
        repeat (3) tick();
        do_start(257, t0);
        repeat (10) tick();
        check("bad_len_rises", rises[0] + rises[1], 0);
        check("bad_len_tcs", tcs_low[0] + tcs_low[1], 0);

        // Full buffer, buffer[i] = i.
        for (int a = 0; a < 256; a++) do_write(a, a);
        clear_stats();
        do_start(256, t0);
        wait_idle(10000);
        for (int i = 0; i < 2; i++) begin
            int bad = 0;
            for (int j = 0; j < 256; j++) if (rx_byte(i, j) != j) bad++;
            check("len256_bytes_bad", bad, 0);
            check("len256_rises", rises[i], 2048);
            check("len256_done_cnt", done_cnt[i], 1);
            check("len256_sent", int'(w_sent[i]), 256);
        end
        check("len256_done_cyc_div1", done_cyc[1], t0 + 4098);
        check("len256_done_cyc_div2", done_cyc[0], t0 + 8195);

        // Reset during a 2-byte send.
        do_write(0, 8'h3C);
        do_write(1, 8'hC3);
        clear_stats();
        do_start(2, t0);
        begin
            int n = 0;
            while (rises[1] < 11 && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) check("reset_wait_timeout", 0, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tcs", int'(w_tcs), 3);
        check("async_rst_tck", int'(w_tck), 0);
        check("async_rst_busy", int'(w_busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_no_done", done_cnt[0] + done_cnt[1], 0);
        check("rst_sent", int'(w_sent[1]), 0);
        clear_stats();
        do_start(1, t0);
        wait_idle(200);
        check("post_rst_done", done_cnt[0] + done_cnt[1], 2);
        check("post_rst_byte", rx_byte(0, 0), 8'h3C);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                int s;
                s = int'($urandom_range(0, 15));
                start = 1'b1;
                if (s == 0) len = 9'd0;
                else if (s == 1) len = 9'(int'($urandom_range(257, 511)));
                else len = 9'(int'($urandom_range(1, 5)));
            end else if (r < 35) begin
                wr_en = 1'b1;
                wr_addr = 8'($urandom_range(0, 255));
                wr_data = 8'($urandom_range(0, 255));
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        wait_idle(1000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
